// File: rtl/pitch_shift_resampler.sv
// Pitch-correction resampler.
// A serial restoring divider turns the estimator's (est_freq, target_freq) pair into
// a Q4.12 playback ratio. Audio is written into a circular buffer at the input rate.
// A fractional read pointer advances by that ratio for every input sample, and the
// output is linearly interpolated between the two neighbouring buffer entries.
// Input-to-output latency is three cycles in both pitch and bypass mode.
module pitch_shift_resampler #(
    parameter int ADDR_W    = 8,
    parameter int FRAC_W    = 12,
    parameter int RATIO_MIN = 2048,
    parameter int RATIO_MAX = 8192,
    parameter int GUARD     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               in_valid,
    input  logic signed [15:0] in_sample,
    input  logic               freq_valid,
    input  logic        [15:0] est_freq,
    input  logic        [15:0] target_freq,
    output logic               out_valid,
    output logic signed [15:0] out_sample,
    output logic        [15:0] ratio,
    output logic               div_busy,
    output logic               resync
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PTR_W  = ADDR_W + FRAC_W;
    localparam int NUM_W  = 16 + FRAC_W;
    localparam int CNT_W  = $clog2(NUM_W);
    localparam int PROD_W = 17 + FRAC_W + 1;
    localparam int Y_W    = 19;

    localparam logic [ADDR_W-1:0] HALF     = ADDR_W'(DEPTH / 2);
    localparam logic [ADDR_W-1:0] GUARD_LO = ADDR_W'(GUARD);
    localparam logic [ADDR_W-1:0] GUARD_HI = ADDR_W'(DEPTH - GUARD);
    localparam logic [15:0]       UNITY    = 16'(1 << FRAC_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(NUM_W - 1);

    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'(32767);
    localparam logic signed [Y_W-1:0] Y_MIN = -Y_W'(32768);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;

    // ------------------------------------------------------------------
    // Ratio divider
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [NUM_W-1:0] div_num;     // dividend shifting out, quotient shifting in
    logic [15:0]      div_rem;
    logic [15:0]      div_den;
    logic [CNT_W-1:0] div_cnt;

    logic             pend_valid;
    logic [15:0]      pend_est;
    logic [15:0]      pend_tgt;

    logic             start_go;
    logic [15:0]      start_est;
    logic [15:0]      start_tgt;

    logic [16:0]      trial;
    logic             take;
    logic [15:0]      rem_next;
    logic [15:0]      q_clamped;

    // Pick the operand pair for a new division: a live strobe beats the pending slot
    always_comb begin
        start_go  = 1'b0;
        start_est = est_freq;
        start_tgt = target_freq;
        if (state == S_IDLE) begin
            if (freq_valid) begin
                start_go = 1'b1;
            end else if (pend_valid) begin
                start_go  = 1'b1;
                start_est = pend_est;
                start_tgt = pend_tgt;
            end
        end
    end

    // One restoring-division step and the final clamp of the quotient
    always_comb begin
        trial    = {div_rem, div_num[NUM_W-1]};
        take     = (trial >= {1'b0, div_den});
        rem_next = take ? 16'(trial - {1'b0, div_den}) : 16'(trial);
        if (div_num < NUM_W'(RATIO_MIN)) begin
            q_clamped = 16'(RATIO_MIN);
        end else if (div_num > NUM_W'(RATIO_MAX)) begin
            q_clamped = 16'(RATIO_MAX);
        end else begin
            q_clamped = div_num[15:0];
        end
    end

    // Divider FSM, pending-pair slot and the active ratio register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_num    <= '0;
            div_rem    <= '0;
            div_den    <= '0;
            div_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_est   <= '0;
            pend_tgt   <= '0;
            ratio      <= UNITY;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_go) begin
                        pend_valid <= 1'b0;
                        div_den    <= start_est;
                        div_rem    <= '0;
                        div_cnt    <= '0;
                        if (start_est == 16'd0 || start_tgt == 16'd0) begin
                            div_num <= NUM_W'(UNITY);
                            state   <= S_APPLY;
                        end else begin
                            div_num <= {start_tgt, FRAC_W'(0)};
                            state   <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    div_num <= {div_num[NUM_W-2:0], take};
                    div_rem <= rem_next;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == LAST_BIT) begin
                        state <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    ratio <= q_clamped;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A pair arriving while busy replaces whatever was waiting
            if (state != S_IDLE && freq_valid) begin
                pend_valid <= 1'b1;
                pend_est   <= est_freq;
                pend_tgt   <= target_freq;
            end
        end
    end

    assign div_busy = (state == S_DIV);

    // ------------------------------------------------------------------
    // Circular buffer and read pointer
    // ------------------------------------------------------------------
    logic signed [15:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] fill_cnt;

    logic [ADDR_W-1:0] new_wr;
    logic [PTR_W-1:0]  rd_sum;
    logic [ADDR_W-1:0] sep;
    logic              collide;
    logic [PTR_W-1:0]  rd_anchor;

    // Stage 1: read address captured with the sample
    logic              st1_valid;
    logic              st1_pitch;
    logic              st1_warm;
    logic              st1_coll;
    logic [ADDR_W-1:0] st1_rd_int;
    logic [ADDR_W-1:0] st1_rd_nx;
    logic [FRAC_W-1:0] st1_frac;
    logic signed [15:0] st1_byp;

    // Stage 2: neighbouring samples fetched, ready to interpolate
    logic              st2_valid;
    logic              st2_pitch;
    logic              st2_warm;
    logic [FRAC_W-1:0] st2_frac;
    logic signed [15:0] st2_byp;
    logic signed [15:0] s0;
    logic signed [15:0] s1;

    logic signed [16:0]       diff;
    logic signed [FRAC_W:0]   frac_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shf;
    logic signed [Y_W-1:0]    y_wide;
    logic signed [15:0]       y_sat;

    // Next pointer values and read/write separation check after this sample's update
    always_comb begin
        new_wr    = wr_ptr + ADDR_W'(1);
        rd_sum    = rd_ptr + PTR_W'(ratio);
        rd_anchor = {new_wr - HALF, FRAC_W'(0)};
        sep       = new_wr - rd_sum[PTR_W-1:FRAC_W];
        collide   = enable && ((sep < GUARD_LO) || (sep > GUARD_HI));
        st1_rd_nx = st1_rd_int + ADDR_W'(1);
    end

    // Linear interpolation between s0 and s1 with saturation to 16 bits
    always_comb begin
        diff   = 17'(s1) - 17'(s0);
        frac_s = $signed({1'b0, st2_frac});
        prod   = PROD_W'(diff) * PROD_W'(frac_s);
        shf    = prod >>> FRAC_W;
        y_wide = Y_W'(s0) + Y_W'(shf);
        if (y_wide > Y_MAX) begin
            y_sat = 16'sh7FFF;
        end else if (y_wide < Y_MIN) begin
            y_sat = -16'sh8000;
        end else begin
            y_sat = 16'(y_wide);
        end
    end

    // Buffer storage: written with each sample, two neighbours read one cycle later
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_ptr] <= in_sample;
        end
        if (st1_valid) begin
            s0 <= mem[st1_rd_int];
            s1 <= mem[st1_rd_nx];
        end
    end

    // Pointer update and the three-stage sample pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= {HALF, FRAC_W'(0)};
            fill_cnt   <= '0;
            st1_valid  <= 1'b0;
            st1_pitch  <= 1'b0;
            st1_warm   <= 1'b0;
            st1_coll   <= 1'b0;
            st1_rd_int <= '0;
            st1_frac   <= '0;
            st1_byp    <= '0;
            st2_valid  <= 1'b0;
            st2_pitch  <= 1'b0;
            st2_warm   <= 1'b0;
            st2_frac   <= '0;
            st2_byp    <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            resync     <= 1'b0;
        end else begin
            st1_valid <= in_valid;
            st2_valid <= st1_valid;
            out_valid <= st2_valid;
            resync    <= st1_valid && st1_coll;

            if (in_valid) begin
                wr_ptr <= new_wr;
                if (fill_cnt < HALF) begin
                    fill_cnt <= fill_cnt + ADDR_W'(1);
                end
                // Bypass and collisions both park the reader half a buffer behind
                rd_ptr     <= (enable && !collide) ? rd_sum : rd_anchor;
                st1_rd_int <= rd_ptr[PTR_W-1:FRAC_W];
                st1_frac   <= enable ? rd_ptr[FRAC_W-1:0] : '0;
                st1_pitch  <= enable;
                st1_warm   <= (fill_cnt < HALF);
                st1_coll   <= collide;
                st1_byp    <= in_sample;
            end

            if (st1_valid) begin
                st2_pitch <= st1_pitch;
                st2_warm  <= st1_warm;
                st2_frac  <= st1_frac;
                st2_byp   <= st1_byp;
            end

            if (st2_valid) begin
                if (st2_pitch) begin
                    out_sample <= st2_warm ? 16'sd0 : y_sat;
                end else begin
                    out_sample <= st2_byp;
                end
            end
        end
    end

endmodule
